// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared types and constants for the JPEG DHT segment parser
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_TCTH,
    ST_BITS,
    ST_VALS
  } dht_state_e;

  localparam logic [1:0] COLOR_YDC = 2'b00;
  localparam logic [1:0] COLOR_YAC = 2'b01;
  localparam logic [1:0] COLOR_CDC = 2'b10;
  localparam logic [1:0] COLOR_CAC = 2'b11;

  localparam int DHT_MIN_LEN        = 19;
  localparam int MAX_DC_SYMBOLS_DEF = 16;
  localparam int MAX_AC_SYMBOLS_DEF = 256;

endpackage

// File: rtl/jpeg_dht_parser.sv
// rtl/jpeg_dht_parser.sv - DHT segment payload parser feeding BITS counts and HUFFVAL symbols
module jpeg_dht_parser
  import jpeg_pkg::*;
#(
  parameter int MAX_DC_SYMBOLS = MAX_DC_SYMBOLS_DEF,
  parameter int MAX_AC_SYMBOLS = MAX_AC_SYMBOLS_DEF
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       Start,
  input  logic       InValid,
  input  logic [7:0] InData,
  output logic       InReady,
  output logic       BitsWrEnable,
  output logic [1:0] BitsWrColor,
  output logic [3:0] BitsWrIndex,
  output logic [7:0] BitsWrData,
  output logic       WrEnable,
  output logic [1:0] WrColor,
  output logic [7:0] WrCount,
  output logic [7:0] WrData,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  dht_state_e  state_q, state_d;
  logic [7:0]  len_hi_q;
  logic [15:0] rem_q;
  logic [1:0]  color_q;
  logic        tc_q;
  logic [3:0]  idx_q;
  logic [11:0] total_q;
  logic [8:0]  sym_q;

  logic        bits_we_q, bits_we_d, wr_en_q, wr_en_d, done_q, done_d, error_q, error_d;
  logic [1:0]  bits_col_q, bits_col_d, wr_col_q, wr_col_d;
  logic [3:0]  bits_idx_q, bits_idx_d;
  logic [7:0]  bits_data_q, bits_data_d, wr_count_q, wr_count_d, wr_data_q, wr_data_d;

  logic        xfer, rem_zero, bits_last, vals_last, over_max, tcth_bad;
  logic        done_c, error_c;
  logic [15:0] lh_w;
  logic [11:0] total_sum, max_sym;

  assign InReady   = (state_q != ST_IDLE);
  assign Busy      = (state_q != ST_IDLE);
  assign xfer      = InValid && InReady && !Start;
  assign lh_w      = {len_hi_q, InData};
  assign rem_zero  = (rem_q == 16'd1);
  assign total_sum = total_q + {4'd0, InData};
  assign max_sym   = tc_q ? 12'(MAX_AC_SYMBOLS) : 12'(MAX_DC_SYMBOLS);
  assign over_max  = (total_sum > max_sym);
  assign bits_last = (idx_q == 4'd15);
  assign vals_last = (({3'd0, sym_q} + 12'd1) == total_q);
  assign tcth_bad  = (InData[7:4] > 4'd1) || (InData[3:0] > 4'd1);

  // Segment outcome of the byte being accepted this cycle
  always_comb begin
    done_c  = 1'b0;
    error_c = 1'b0;
    if (xfer) begin
      case (state_q)
        ST_LEN_L: error_c = (lh_w < 16'(DHT_MIN_LEN));
        ST_TCTH:  error_c = tcth_bad || rem_zero;
        ST_BITS: begin
          if (bits_last) begin
            error_c = over_max || ((total_sum != 12'd0) && rem_zero);
            done_c  = !over_max && (total_sum == 12'd0) && rem_zero;
          end else begin
            error_c = rem_zero;
          end
        end
        ST_VALS: begin
          error_c = !vals_last && rem_zero;
          done_c  = vals_last && rem_zero;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = ST_LEN_H;
    end else if (error_c || done_c) begin
      state_d = ST_IDLE;
    end else if (xfer) begin
      case (state_q)
        ST_LEN_H: state_d = ST_LEN_L;
        ST_LEN_L: state_d = ST_TCTH;
        ST_TCTH:  state_d = ST_BITS;
        ST_BITS:  if (bits_last) state_d = (total_sum == 12'd0) ? ST_TCTH : ST_VALS;
        ST_VALS:  if (vals_last) state_d = ST_TCTH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bits_we_d   = 1'b0;
    bits_col_d  = 2'd0;
    bits_idx_d  = 4'd0;
    bits_data_d = 8'd0;
    wr_en_d     = 1'b0;
    wr_col_d    = 2'd0;
    wr_count_d  = 8'd0;
    wr_data_d   = 8'd0;
    done_d      = done_c;
    error_d     = error_c;
    if (xfer && state_q == ST_BITS) begin
      bits_we_d   = 1'b1;
      bits_col_d  = color_q;
      bits_idx_d  = idx_q;
      bits_data_d = InData;
    end
    if (xfer && state_q == ST_VALS) begin
      wr_en_d    = 1'b1;
      wr_col_d   = color_q;
      wr_count_d = sym_q[7:0];
      wr_data_d  = InData;
    end
  end

  // Datapath counters; Remaining only moves on transfers after LEN_L
  always_ff @(posedge clk or posedge rst) begin
    if (rst || Start) begin
      len_hi_q <= 8'd0;
      rem_q    <= 16'd0;
      color_q  <= 2'd0;
      tc_q     <= 1'b0;
      idx_q    <= 4'd0;
      total_q  <= 12'd0;
      sym_q    <= 9'd0;
    end else if (xfer) begin
      case (state_q)
        ST_LEN_H: len_hi_q <= InData;
        ST_LEN_L: rem_q <= lh_w - 16'd2;
        ST_TCTH: begin
          rem_q   <= rem_q - 16'd1;
          color_q <= {InData[0], InData[4]};
          tc_q    <= InData[4];
          idx_q   <= 4'd0;
          total_q <= 12'd0;
        end
        ST_BITS: begin
          rem_q   <= rem_q - 16'd1;
          idx_q   <= idx_q + 4'd1;
          total_q <= total_sum;
          sym_q   <= 9'd0;
        end
        ST_VALS: begin
          rem_q <= rem_q - 16'd1;
          sym_q <= sym_q + 9'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_we_q   <= 1'b0;
      bits_col_q  <= 2'd0;
      bits_idx_q  <= 4'd0;
      bits_data_q <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_col_q    <= 2'd0;
      wr_count_q  <= 8'd0;
      wr_data_q   <= 8'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      bits_we_q   <= bits_we_d;
      bits_col_q  <= bits_col_d;
      bits_idx_q  <= bits_idx_d;
      bits_data_q <= bits_data_d;
      wr_en_q     <= wr_en_d;
      wr_col_q    <= wr_col_d;
      wr_count_q  <= wr_count_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign BitsWrEnable = bits_we_q;
  assign BitsWrColor  = bits_col_q;
  assign BitsWrIndex  = bits_idx_q;
  assign BitsWrData   = bits_data_q;
  assign WrEnable     = wr_en_q;
  assign WrColor      = wr_col_q;
  assign WrCount      = wr_count_q;
  assign WrData       = wr_data_q;
  assign Done         = done_q;
  assign Error        = error_q;

endmodule

// File: tb/tb_jpeg_dht_parser.sv
// tb/tb_jpeg_dht_parser.sv - scoreboard bench for the DHT segment parser
module tb_jpeg_dht_parser;
  import jpeg_pkg::*;

  logic       rst, clk, Start, InValid;
  logic [7:0] InData;
  logic       InReady, BitsWrEnable, WrEnable, Busy, Done, Error;
  logic [1:0] BitsWrColor, WrColor;
  logic [3:0] BitsWrIndex;
  logic [7:0] BitsWrData, WrCount, WrData;

  jpeg_dht_parser #(.MAX_DC_SYMBOLS(16), .MAX_AC_SYMBOLS(256)) dut (
    .rst(rst), .clk(clk), .Start(Start), .InValid(InValid), .InData(InData),
    .InReady(InReady), .BitsWrEnable(BitsWrEnable), .BitsWrColor(BitsWrColor),
    .BitsWrIndex(BitsWrIndex), .BitsWrData(BitsWrData), .WrEnable(WrEnable),
    .WrColor(WrColor), .WrCount(WrCount), .WrData(WrData), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  typedef struct {
    int         stamp;
    logic [1:0] color;
    logic [7:0] idx;
    logic [7:0] data;
  } wr_t;
  typedef struct {
    int stamp;
    bit is_err;
  } ev_t;

  wr_t bits_sb[$];
  wr_t sym_sb[$];
  ev_t ev_sb[$];
  int  total = 0;
  int  bad = 0;
  bit  gaps_en = 1'b0;
  wr_t mw;
  ev_t me;
  logic [7:0] dc_bits [16];
  logic [7:0] ac_bits [16];

  // Output monitor: every strobe must match the head of its queue at the exact stamped cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (BitsWrEnable) begin
        total++;
        if (bits_sb.size() == 0) begin
          bad++;
          $display("FAIL bits_unexpected idx=%0d data=%02h required none", BitsWrIndex, BitsWrData);
        end else begin
          mw = bits_sb.pop_front();
          if (mw.stamp != pos_cnt || mw.color !== BitsWrColor || mw.idx[3:0] !== BitsWrIndex || mw.data !== BitsWrData) begin
            bad++;
            $display("FAIL bits_write cyc=%0d col=%0d idx=%0d data=%02h required cyc=%0d col=%0d idx=%0d data=%02h",
                     pos_cnt, BitsWrColor, BitsWrIndex, BitsWrData, mw.stamp, mw.color, mw.idx[3:0], mw.data);
          end
        end
      end else if (bits_sb.size() > 0 && bits_sb[0].stamp <= pos_cnt) begin
        total++; bad++;
        $display("FAIL bits_missing cyc=%0d required idx=%0d data=%02h", pos_cnt, bits_sb[0].idx, bits_sb[0].data);
        void'(bits_sb.pop_front());
      end
      if (WrEnable) begin
        total++;
        if (sym_sb.size() == 0) begin
          bad++;
          $display("FAIL sym_unexpected count=%0d data=%02h required none", WrCount, WrData);
        end else begin
          mw = sym_sb.pop_front();
          if (mw.stamp != pos_cnt || mw.color !== WrColor || mw.idx !== WrCount || mw.data !== WrData) begin
            bad++;
            $display("FAIL sym_write cyc=%0d col=%0d count=%0d data=%02h required cyc=%0d col=%0d count=%0d data=%02h",
                     pos_cnt, WrColor, WrCount, WrData, mw.stamp, mw.color, mw.idx, mw.data);
          end
        end
      end else if (sym_sb.size() > 0 && sym_sb[0].stamp <= pos_cnt) begin
        total++; bad++;
        $display("FAIL sym_missing cyc=%0d required count=%0d data=%02h", pos_cnt, sym_sb[0].idx, sym_sb[0].data);
        void'(sym_sb.pop_front());
      end
      if (Done || Error) begin
        total++;
        if (ev_sb.size() == 0) begin
          bad++;
          $display("FAIL event_unexpected done=%b error=%b required none", Done, Error);
        end else begin
          me = ev_sb.pop_front();
          if (me.stamp != pos_cnt || Done !== !me.is_err || Error !== me.is_err) begin
            bad++;
            $display("FAIL event cyc=%0d done=%b error=%b required cyc=%0d error=%b",
                     pos_cnt, Done, Error, me.stamp, me.is_err);
          end
        end
      end else if (ev_sb.size() > 0 && ev_sb[0].stamp <= pos_cnt) begin
        total++; bad++;
        $display("FAIL event_missing cyc=%0d required error=%b", pos_cnt, ev_sb[0].is_err);
        void'(ev_sb.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ev: 0 none, 1 Done, 2 Error
  task automatic send(input logic [7:0] b, input bit has_bits, input logic [3:0] bidx,
                      input bit has_sym, input logic [7:0] scnt, input logic [1:0] col, input int ev);
    wr_t w;
    ev_t e;
    if (gaps_en) begin
      InValid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    w.stamp = pos_cnt + 1;
    w.color = col;
    w.data  = b;
    if (has_bits) begin w.idx = {4'd0, bidx}; bits_sb.push_back(w); end
    if (has_sym)  begin w.idx = scnt; sym_sb.push_back(w); end
    if (ev != 0) begin e.stamp = pos_cnt + 1; e.is_err = (ev == 2); ev_sb.push_back(e); end
    InValid = 1'b1;
    InData  = b;
    tick();
    InValid = 1'b0;
  endtask

  task automatic send_plain(input logic [7:0] b);
    send(b, 1'b0, 4'd0, 1'b0, 8'd0, 2'd0, 0);
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    total++;
    if (Busy !== 1'b1 || InReady !== 1'b1) begin
      bad++;
      $display("FAIL start_busy busy=%b inready=%b required 1 1", Busy, InReady);
    end
  endtask

  task automatic start_seg(input logic [15:0] lh);
    start_pulse();
    send_plain(lh[15:8]);
    send_plain(lh[7:0]);
  endtask

  // err_at: -1 clean, -2 Error on 16th BITS byte, n>=0 Error on value n
  task automatic send_table(input logic [7:0] tcth, input logic [7:0] bits [16],
                            input int val_base, input bit is_last, input int err_at);
    logic [1:0] col;
    int sum, ev;
    col = {tcth[0], tcth[4]};
    sum = 0;
    for (int i = 0; i < 16; i++) sum += int'(bits[i]);
    send_plain(tcth);
    for (int i = 0; i < 16; i++) begin
      ev = 0;
      if (i == 15) begin
        if (err_at == -2) ev = 2;
        else if (sum == 0 && is_last) ev = 1;
      end
      send(bits[i], 1'b1, 4'(i), 1'b0, 8'd0, col, ev);
      if (ev == 2) return;
    end
    for (int i = 0; i < sum; i++) begin
      ev = (i == err_at) ? 2 : ((i == sum - 1 && is_last) ? 1 : 0);
      send(8'(val_base + i), 1'b0, 4'd0, 1'b1, 8'(i), col, ev);
      if (ev == 2) return;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((bits_sb.size() + sym_sb.size() + ev_sb.size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    total++;
    if ((bits_sb.size() + sym_sb.size() + ev_sb.size()) != 0) begin
      bad++;
      $display("FAIL %s_drain pending bits=%0d sym=%0d ev=%0d required 0 0 0",
               name, bits_sb.size(), sym_sb.size(), ev_sb.size());
      bits_sb.delete(); sym_sb.delete(); ev_sb.delete();
    end
    total++;
    if (Busy !== 1'b0 || InReady !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle busy=%b inready=%b required 0 0", name, Busy, InReady);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; InValid = 1'b0; InData = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({InReady, Busy, Done, Error, BitsWrEnable, BitsWrColor, BitsWrIndex, BitsWrData,
         WrEnable, WrColor, WrCount, WrData} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs inready=%b busy=%b done=%b error=%b bwe=%b we=%b required all 0",
               InReady, Busy, Done, Error, BitsWrEnable, WrEnable);
    end
  endtask

  task automatic test_dc_table();
    start_seg(16'h001F);
    send_table(8'h00, dc_bits, 0, 1'b1, -1);
    drain("dc_table");
  endtask

  task automatic test_two_tables();
    start_seg(16'd60);
    send_table(8'h01, dc_bits, 0, 1'b0, -1);
    send_table(8'h11, dc_bits, 8'h20, 1'b1, -1);
    drain("two_tables");
  endtask

  task automatic test_ac256();
    start_seg(16'd275);
    send_table(8'h10, ac_bits, 0, 1'b1, -1);
    drain("ac256");
  endtask

  task automatic test_ac257();
    logic [7:0] b [16];
    b = ac_bits;
    b[15] = 8'd17;
    start_seg(16'd276);
    send_table(8'h10, b, 0, 1'b1, -2);
    drain("ac257");
  endtask

  task automatic test_malformed();
    start_pulse();
    send_plain(8'h00);
    send(8'h10, 1'b0, 4'd0, 1'b0, 8'd0, 2'd0, 2);
    drain("short_lh");
    start_seg(16'h001F);
    send(8'h02, 1'b0, 4'd0, 1'b0, 8'd0, 2'd0, 2);
    drain("bad_tcth");
    start_seg(16'd30);
    send_table(8'h00, dc_bits, 0, 1'b1, 10);
    drain("underrun");
  endtask

  task automatic test_gaps();
    gaps_en = 1'b1;
    start_seg(16'h001F);
    send_table(8'h00, dc_bits, 0, 1'b1, -1);
    gaps_en = 1'b0;
    drain("gaps");
  endtask

  task automatic test_restart();
    start_seg(16'h001F);
    send_plain(8'h00);
    for (int i = 0; i < 16; i++) send(dc_bits[i], 1'b1, 4'(i), 1'b0, 8'd0, 2'd0, 0);
    for (int i = 0; i < 5; i++) send(8'(i), 1'b0, 4'd0, 1'b1, 8'(i), 2'd0, 0);
    start_seg(16'h001F);
    send_table(8'h00, dc_bits, 8'h40, 1'b1, -1);
    drain("restart");
  endtask

  task automatic test_reset_mid();
    start_seg(16'h001F);
    send_plain(8'h00);
    for (int i = 0; i < 5; i++) send(dc_bits[i], 1'b1, 4'(i), 1'b0, 8'd0, 2'd0, 0);
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({InReady, Busy, Done, Error, BitsWrEnable, WrEnable} !== 6'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs inready=%b busy=%b done=%b error=%b bwe=%b we=%b required all 0",
               InReady, Busy, Done, Error, BitsWrEnable, WrEnable);
    end
    tick();
    rst = 1'b0;
    InValid = 1'b1;
    InData = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (InReady !== 1'b0 || Busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_idle inready=%b busy=%b required 0 0", InReady, Busy);
      end
    end
    InValid = 1'b0;
    start_seg(16'h001F);
    send_table(8'h00, dc_bits, 0, 1'b1, -1);
    drain("reset_mid");
  endtask

  initial begin
    dc_bits = '{8'h00, 8'h01, 8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) ac_bits[i] = 8'd16;
    test_reset();
    test_dc_table();
    test_two_tables();
    test_ac256();
    test_ac257();
    test_malformed();
    test_gaps();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
